// File: rtl/alu_seq.sv
// alu_seq: byte-serial command sequencer for the 8-bit ALU; owns the CCR.
// Define ALU_SEQ_WIDE_EN to enable 16-bit ops (HI/FIX states).
module alu_seq (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_sel,
    input  logic [7:0]  alu_result,
    input  logic [3:0]  alu_nzvc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [3:0]  rsp_nzvc,
    output logic [3:0]  ccr
);

    typedef enum logic [2:0] {IDLE, LO, HI, FIX, RESP} state_t;

    localparam logic [2:0] SEL_ADD = 3'b000;
    localparam logic [2:0] SEL_INC = 3'b001;
    localparam logic [2:0] SEL_SUB = 3'b010;
    localparam logic [2:0] SEL_DEC = 3'b011;
    localparam logic [2:0] SEL_OR  = 3'b101;

    state_t state;

`ifdef ALU_SEQ_WIDE_EN
    logic        wide_q;
    logic [2:0]  op_q;
    logic [7:0]  a_hi;
    logic [7:0]  b_hi;
    logic [7:0]  r_lo;
    logic        c0;
    logic        c1;
    logic        is_arith;
    logic        is_step;
    logic [15:0] fin_r;
    logic        fin_c;
    logic [3:0]  fin_nzvc;

    function automatic logic [3:0] wide_flags(
        input logic [2:0]  op,
        input logic        a15,
        input logic        b15,
        input logic [15:0] r,
        input logic        c
    );
        logic v;
        unique case (op)
            SEL_ADD: v = (a15 == b15) && (r[15] != a15);
            SEL_SUB: v = (a15 != b15) && (r[15] != a15);
            SEL_INC: v = !a15 && r[15];
            SEL_DEC: v = a15 && !r[15];
            default: v = 1'b0;
        endcase
        return {r[15], r == 16'h0, v, c};
    endfunction

    assign is_arith = (op_q == SEL_ADD) || (op_q == SEL_SUB);
    assign is_step  = (op_q == SEL_INC) || (op_q == SEL_DEC);

    // Final flags for the byte being captured on the way into RESP.
    always_comb begin
        fin_r = {alu_result, r_lo};
        fin_c = 1'b0;
        if (state == FIX)
            fin_c = c1 | alu_nzvc[0];
        else if (is_arith)
            fin_c = alu_nzvc[0];
        else if (is_step)
            fin_c = c0 & alu_nzvc[0];
        fin_nzvc = wide_flags(op_q, a_hi[7], b_hi[7], fin_r, fin_c);
    end
`else
    logic unused_hi;
    assign unused_hi = ^{cmd_op[3], cmd_a[15:8], cmd_b[15:8]};
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_result <= 16'h0;
            rsp_nzvc   <= 4'h0;
            ccr        <= 4'h0;
            alu_a      <= 8'h0;
            alu_b      <= 8'h0;
            alu_sel    <= SEL_ADD;
`ifdef ALU_SEQ_WIDE_EN
            wide_q     <= 1'b0;
            op_q       <= SEL_ADD;
            a_hi       <= 8'h0;
            b_hi       <= 8'h0;
            r_lo       <= 8'h0;
            c0         <= 1'b0;
            c1         <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: if (cmd_valid) begin
                    state     <= LO;
                    cmd_ready <= 1'b0;
                    alu_sel   <= cmd_op[2:0];
                    alu_a     <= cmd_a[7:0];
                    alu_b     <= cmd_b[7:0];
`ifdef ALU_SEQ_WIDE_EN
                    wide_q    <= cmd_op[3];
                    op_q      <= cmd_op[2:0];
                    a_hi      <= cmd_a[15:8];
                    b_hi      <= cmd_b[15:8];
`endif
                end
                LO: begin
`ifdef ALU_SEQ_WIDE_EN
                    r_lo <= alu_result;
                    c0   <= alu_nzvc[0];
                    // INC/DEC without low carry just copy the high byte.
                    if (wide_q) begin
                        state   <= HI;
                        alu_a   <= a_hi;
                        alu_b   <= is_step ? 8'h00 : b_hi;
                        alu_sel <= (is_step && !alu_nzvc[0]) ? SEL_OR : op_q;
                    end else
`endif
                    begin
                        state      <= RESP;
                        rsp_valid  <= 1'b1;
                        rsp_result <= {8'h00, alu_result};
                        rsp_nzvc   <= alu_nzvc;
                        ccr        <= alu_nzvc;
                        alu_a      <= 8'h0;
                        alu_b      <= 8'h0;
                        alu_sel    <= SEL_ADD;
                    end
                end
`ifdef ALU_SEQ_WIDE_EN
                HI: begin
                    c1 <= alu_nzvc[0];
                    if (is_arith && c0) begin
                        state   <= FIX;
                        alu_a   <= alu_result;
                        alu_b   <= 8'h00;
                        alu_sel <= (op_q == SEL_ADD) ? SEL_INC : SEL_DEC;
                    end else begin
                        state      <= RESP;
                        rsp_valid  <= 1'b1;
                        rsp_result <= fin_r;
                        rsp_nzvc   <= fin_nzvc;
                        ccr        <= fin_nzvc;
                        alu_a      <= 8'h0;
                        alu_b      <= 8'h0;
                        alu_sel    <= SEL_ADD;
                    end
                end
                FIX: begin
                    state      <= RESP;
                    rsp_valid  <= 1'b1;
                    rsp_result <= fin_r;
                    rsp_nzvc   <= fin_nzvc;
                    ccr        <= fin_nzvc;
                    alu_a      <= 8'h0;
                    alu_b      <= 8'h0;
                    alu_sel    <= SEL_ADD;
                end
`endif
                RESP: if (rsp_ready) begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-cycle command sequencer that acts as the initiator for the combinational 8-bit ALU. It accepts 8- or 16-bit operation commands over a valid/ready handshake and drives the ALU operand and select lines one byte at a time. It captures the ALU result and NZVC flags, chaining carry and borrow across bytes for wide operations, and returns a 16-bit result plus flags over a second valid/ready handshake. It sits between the CPU control unit and the ALU and owns the architectural condition-code register.

## Interface
Parameters: none.

Ports:
- `clock`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_op`  in  4  bit 3 selects wide (16-bit); bits 2:0 use the ALU select encoding (000 ADD, 001 INC, 010 SUB, 011 DEC, 100 AND, 101 OR, 110 XOR, 111 NOT).
- `cmd_a`, `cmd_b`  in  16  operands; 8-bit ops use bits 7:0 only.
- `alu_a`, `alu_b`  out  8  ALU operands.
- `alu_sel`  out  3  ALU select.
- `alu_result`  in  8  ALU result.
- `alu_nzvc`  in  4  ALU flags {N,Z,V,C}.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_result`  out  16  result; 8-bit ops zero-extend.
- `rsp_nzvc`  out  4  flags for this result.
- `ccr`  out  4  condition-code register, {N,Z,V,C}.

## Operation
- States: IDLE, LO, HI, FIX, RESP.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`, latch op and operands. Go to LO.
- LO: drive `alu_sel`=op[2:0], `alu_a`=a[7:0], `alu_b`=b[7:0]. Capture `alu_result` into r_lo and `alu_nzvc[0]` into c0.
  - 8-bit op: set `rsp_nzvc`=`alu_nzvc`, then go to RESP.
  - Wide op: go to HI.
- HI (wide ops only), drives per op:
  - ADD/SUB/logic: op[2:0] on a[15:8], b[15:8].
  - INC/DEC: `alu_sel`=op[2:0] on a[15:8] if c0=1. Otherwise pass-through: `alu_sel`=101, `alu_b`=0.
  - Capture r_hi and c1.
  - Next state: ADD/SUB with c0=1 goes to FIX; everything else goes to RESP.
- FIX: apply the low-byte carry/borrow to the high byte.
  - ADD: `alu_sel`=001 on r_hi.
  - SUB: `alu_sel`=011 on r_hi.
  - Capture the new r_hi and c2. C = c1|c2. Go to RESP.
- Wide flag rules, computed locally with r = {r_hi, r_lo}:
  - N = r[15].
  - Z = (r==0).
  - C: ADD/SUB use the chained carry/borrow. INC/DEC use the high-byte carry if the high byte was incremented or decremented, else 0. Logic ops give 0.
  - V for ADD: a15==b15 && r15!=a15.
  - V for SUB: a15!=b15 && r15!=a15.
  - V for INC: !a15 && r15.
  - V for DEC: a15 && !r15.
  - V for logic ops: 0.
- RESP:
  - `rsp_valid`=1. `rsp_result` and `rsp_nzvc` are held stable until `rsp_ready`.
  - On handshake, go to IDLE.
- `ccr` loads `rsp_nzvc` on the cycle of entering RESP.
- In IDLE and RESP, `alu_a`=`alu_b`=0 and `alu_sel`=000.

## Timing
- Reset values: state IDLE, `cmd_ready`=1, `rsp_valid`=0, `rsp_result`=0, `rsp_nzvc`=0, `ccr`=0, `alu_a`=`alu_b`=0, `alu_sel`=000.
- The ALU is combinational: drive and capture happen in the same cycle.
- Command accepted at edge k:
  - 8-bit op: `rsp_valid` high from cycle k+2.
  - Wide logic, INC, DEC, and ADD/SUB without low carry: cycle k+3.
  - Wide ADD/SUB with low carry: cycle k+4.
- `cmd_ready` is 0 in every state except IDLE. No new command is accepted on the same edge as the response handshake; the next accept is earliest one cycle after it.
- `rsp_ready` held low: the sequencer stays in RESP indefinitely and the outputs do not change.
- Reset mid-operation: immediate abort, no response issued, `ccr` cleared.

## Configuration
- `ALU_SEQ_WIDE_EN` defined:
  - 16-bit ops are supported as described.
  - HI and FIX states exist.
- `ALU_SEQ_WIDE_EN` undefined:
  - `cmd_op[3]` is ignored and every op runs as 8-bit (LO then RESP).
  - `cmd_a[15:8]` and `cmd_b[15:8]` are ignored.
  - `rsp_result[15:8]` is always 0.

## Test plan
- ADD8, a=0x007F, b=0x0001 -> `rsp_result`=0x0080, `rsp_nzvc`=1010, `rsp_valid` at k+2, `ccr`=1010.
- ADD16, a=0x00FF, b=0x0001 -> passes through the FIX state, `rsp_result`=0x0100, `rsp_nzvc`=0000, `rsp_valid` at k+4.
- SUB16, a=0x0000, b=0x0001 -> `rsp_result`=0xFFFF, `rsp_nzvc`=1001.
- INC16, a=0x7FFF -> `rsp_result`=0x8000, `rsp_nzvc`=1010. DEC16, a=0x0105 -> pass-through high byte, `rsp_result`=0x0104, `rsp_nzvc`=0000.
- Backpressure: hold `rsp_ready`=0 for 5 cycles after `rsp_valid` -> result stable and `cmd_ready`=0 throughout. Accept, then `cmd_ready`=1 the next cycle.
- Reset asserted during the HI state of an ADD16 -> all outputs return to reset values immediately and no `rsp_valid` pulse occurs. A fresh AND8, a=0xF0, b=0x3C, then gives 0x0030, NZVC=0000.
